// File: rtl/data_ram_pkg.sv
// Shared encodings and helpers for the byte-addressable data memory.
package data_ram_pkg;

  // Access size encodings carried on the size port.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Controller states: zeroing sweep, then normal access.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // An access is illegal when it straddles its natural alignment or uses the reserved size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lane[0];
      SZ_W:    bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Lane steering between a 32-bit memory word and a right-aligned byte/half/word value.
// LOAD=0: replicates din across lanes for a store. LOAD=1: extracts and extends din for a load.
// mask marks the lanes touched by the access and is all-zero for an illegal access.
module ram_lane_align
  import data_ram_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [3:0]  mask
);

  logic [31:0] shifted;
  logic [31:0] ext_word;
  logic [31:0] rep_word;

  assign shifted = din >> {lane, 3'b000};

  // Lane mask plus both data views; the parameter picks which view leaves the block.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path can infer a latch.
    mask     = 4'b0000;
    ext_word = '0;
    rep_word = '0;
    if (!is_misaligned(size, lane)) begin
      case (size)
        SZ_B: begin
          mask     = 4'b0001 << lane;
          ext_word = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
          rep_word = {4{din[7:0]}};
        end
        SZ_H: begin
          mask     = lane[1] ? 4'b1100 : 4'b0011;
          ext_word = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
          rep_word = {2{din[15:0]}};
        end
        default: begin
          mask     = 4'b1111;
          ext_word = din;
          rep_word = din;
        end
      endcase
    end
  end

  assign dout = LOAD ? ext_word : rep_word;

endmodule

// File: rtl/data_ram_ctrl.sv
// Byte-addressable data memory for the single-cycle core: combinational loads,
// clock-edge stores with lane enables, and a post-reset zeroing sweep.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              ready
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [31:0]      mem [DEPTH];
  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_ptr;
  logic             ready_q;
  logic             clr_en;
  logic             st_en;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      st_word;
  logic [3:0]       st_mask;
  logic [31:0]      ld_word;
  logic [3:0]       ld_mask;

  assign idx      = addr[ADDR_W-1:2];
  assign lane     = addr[1:0];
  assign misalign = is_misaligned(size, lane);

  ram_lane_align #(.LOAD(1'b0)) u_store_align (
    .size     (size),
    .lane     (lane),
    .sign_ext (1'b0),
    .din      (wdata),
    .dout     (st_word),
    .mask     (st_mask)
  );

  ram_lane_align #(.LOAD(1'b1)) u_load_align (
    .size     (size),
    .lane     (lane),
    .sign_ext (sign_ext),
    .din      (mem[idx]),
    .dout     (ld_word),
    .mask     (ld_mask)
  );

  // Stores only land once the sweep is finished, the access is legal and reset is low.
  assign st_en = ready_q & we & ~misalign & ~rst;

  // Next-state logic: the sweep ends after writing the last word.
  always_comb begin
    state_nxt = state;
    clr_en    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_en = 1'b1;
        if (&clr_ptr) state_nxt = ST_RUN;
      end
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // State, sweep pointer and registered ready flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_ptr <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_RUN);
      if (clr_en) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // Array write port: sweep zeroing or per-lane store merge.
  always_ff @(posedge clk) begin
    // NOTE: the array itself is never reset; the sweep clears it so it can map onto RAM macros.
    if (!rst) begin
      if (clr_en) begin
        mem[clr_ptr] <= '0;
      end else if (st_en) begin
        for (int i = 0; i < 4; i++) begin
          if (st_mask[i]) mem[idx][8*i +: 8] <= st_word[8*i +: 8];
        end
      end
    end
  end

  assign ready = ready_q;
  assign rdata = (ready_q && (ld_mask != 4'b0000)) ? ld_word : '0;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl with a 16-word array: sweep timing, lane
// steering, extension, misalignment and reset behaviour, in both clear modes.
module tb_data_ram_ctrl;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          we;
  logic [1:0]    size;
  logic          sign_ext;
  logic [31:0]   rdata;
  logic          misalign;
  logic          ready;

  logic          rst_nc;
  logic [AW-1:0] addr_nc;
  logic [31:0]   wdata_nc;
  logic          we_nc;
  logic [1:0]    size_nc;
  logic [31:0]   rdata_nc;
  logic          misalign_nc;
  logic          ready_nc;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .rdata    (rdata),
    .misalign (misalign),
    .ready    (ready)
  );

  data_ram_ctrl #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk      (clk),
    .rst      (rst_nc),
    .addr     (addr_nc),
    .wdata    (wdata_nc),
    .we       (we_nc),
    .size     (size_nc),
    .sign_ext (1'b0),
    .rdata    (rdata_nc),
    .misalign (misalign_nc),
    .ready    (ready_nc)
  );

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          se;
    logic [31:0]   exp_rdata;
    logic          exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic se);
    we = w; size = sz; addr = a; wdata = d; sign_ext = se;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic w, input logic [1:0] sz, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic se, input logic [31:0] er, input logic em);
    vec_t v;
    v.we = w; v.size = sz; v.addr = a; v.wdata = d; v.se = se;
    v.exp_rdata = er; v.exp_mis = em;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; rst_nc = 1'b1;
    drive(1'b0, 2'b10, '0, '0, 1'b0);
    we_nc = 1'b0; size_nc = 2'b10; addr_nc = '0; wdata_nc = '0;

    // Reset state.
    step(); step();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rdata", rdata, 32'd0);

    // First sweep: ready after exactly 16 edges.
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("sweep1_ready_e%0d", i), {31'd0, ready}, {31'd0, (i >= 16)});
    end

    // Pre-fill every word with a nonzero pattern.
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 2'b10, AW'(w * 4), 32'hA500_0000 | 32'(w), 1'b0);
      step();
    end
    drive(1'b0, 2'b10, 6'h3C, '0, 1'b0);
    #2 check("prefill_word15", rdata, 32'hA500_000F);

    // Restart, abort the sweep at word 7.
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    #2 check("notready_rdata_zero", rdata, 32'd0);
    drive(1'b0, 2'b10, 6'h06, '0, 1'b0);
    #1 check("notready_misalign", {31'd0, misalign}, 32'd1);
    check("notready_misalign_rdata", rdata, 32'd0);
    rst = 1'b1; step();
    rst = 1'b0;

    // Second sweep with stores issued while not ready; all must be dropped.
    for (int i = 1; i <= 16; i++) begin
      if (i >= 5) drive(1'b1, 2'b10, 6'h08, 32'h1111_1111, 1'b0);
      else        drive(1'b0, 2'b10, 6'h08, 32'h0, 1'b0);
      step();
      check($sformatf("sweep2_ready_e%0d", i), {31'd0, ready}, {31'd0, (i >= 16)});
    end
    for (int w = 0; w < 16; w++) begin
      drive(1'b0, 2'b10, AW'(w * 4), '0, 1'b0);
      #1 check($sformatf("cleared_word%0d", w), rdata, 32'd0);
    end

    // Directed access table (rdata/misalign checked before the store commits).
    add(1, 2'b10, 6'h08, 32'hDEADBEEF, 0, 32'h0000_0000, 0);
    add(0, 2'b00, 6'h0B, 32'h0,        1, 32'hFFFF_FFDE, 0);
    add(0, 2'b00, 6'h0B, 32'h0,        0, 32'h0000_00DE, 0);
    add(1, 2'b01, 6'h0A, 32'hFFFF1234, 0, 32'h0000_DEAD, 0);
    add(0, 2'b10, 6'h08, 32'h0,        0, 32'h1234_BEEF, 0);
    add(0, 2'b01, 6'h0A, 32'h0,        1, 32'h0000_1234, 0);
    add(0, 2'b01, 6'h08, 32'h0,        1, 32'hFFFF_BEEF, 0);
    add(1, 2'b10, 6'h06, 32'hCAFEF00D, 0, 32'h0000_0000, 1);
    add(0, 2'b10, 6'h04, 32'h0,        0, 32'h0000_0000, 0);
    add(1, 2'b11, 6'h04, 32'h5555_5555, 0, 32'h0000_0000, 1);
    add(0, 2'b10, 6'h04, 32'h0,        0, 32'h0000_0000, 0);
    add(0, 2'b01, 6'h09, 32'h0,        1, 32'h0000_0000, 1);
    add(1, 2'b00, 6'h0C, 32'h12345680, 0, 32'h0000_0000, 0);
    add(1, 2'b00, 6'h0E, 32'h0000007F, 0, 32'h0000_0000, 0);
    add(0, 2'b10, 6'h0C, 32'h0,        0, 32'h007F_0080, 0);
    add(0, 2'b00, 6'h0C, 32'h0,        1, 32'hFFFF_FF80, 0);
    add(0, 2'b00, 6'h0E, 32'h0,        1, 32'h0000_007F, 0);
    add(0, 2'b10, 6'h08, 32'h0,        1, 32'h1234_BEEF, 0);
    add(1, 2'b00, 6'h09, 32'h000000AA, 0, 32'h0000_00BE, 0);
    add(0, 2'b10, 6'h08, 32'h0,        0, 32'h1234_AAEF, 0);
    add(1, 2'b01, 6'h00, 32'h00008001, 0, 32'h0000_0000, 0);
    add(0, 2'b01, 6'h00, 32'h0,        1, 32'hFFFF_8001, 0);
    add(0, 2'b01, 6'h02, 32'h0,        1, 32'h0000_0000, 0);
    add(1, 2'b10, 6'h3C, 32'h0BADCAFE, 0, 32'h0000_0000, 0);
    add(0, 2'b10, 6'h3C, 32'h0,        0, 32'h0BAD_CAFE, 0);
    add(0, 2'b00, 6'h3F, 32'h0,        1, 32'h0000_000B, 0);
    add(1, 2'b10, 6'h10, 32'h11223344, 0, 32'h0000_0000, 0);
    add(1, 2'b10, 6'h10, 32'h55667788, 0, 32'h1122_3344, 0);
    add(0, 2'b10, 6'h10, 32'h0,        0, 32'h5566_7788, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].we, vecs[k].size, vecs[k].addr, vecs[k].wdata, vecs[k].se);
      #2;
      check($sformatf("vec%0d_rdata", k), rdata, vecs[k].exp_rdata);
      check($sformatf("vec%0d_misalign", k), {31'd0, misalign}, {31'd0, vecs[k].exp_mis});
      step();
    end
    drive(1'b0, 2'b10, '0, '0, 1'b0);

    // No-clear instance: ready on first edge, contents kept, reset-cycle store discarded.
    check("nc_reset_ready", {31'd0, ready_nc}, 32'd0);
    rst_nc = 1'b0;
    step();
    check("nc_ready_first_edge", {31'd0, ready_nc}, 32'd1);
    we_nc = 1'b1; addr_nc = 6'h14; wdata_nc = 32'hCAFEBABE; step();
    addr_nc = 6'h18; wdata_nc = 32'h0000_0001; step();
    rst_nc = 1'b1; addr_nc = 6'h14; wdata_nc = 32'h1234_5678; step();
    #1 check("nc_in_reset_ready", {31'd0, ready_nc}, 32'd0);
    check("nc_in_reset_rdata", rdata_nc, 32'd0);
    rst_nc = 1'b0; addr_nc = 6'h18; wdata_nc = 32'h0000_0099;
    step();
    we_nc = 1'b0;
    check("nc_ready_after_reset", {31'd0, ready_nc}, 32'd1);
    addr_nc = 6'h14;
    #1 check("nc_store_in_reset_dropped", rdata_nc, 32'hCAFE_BABE);
    addr_nc = 6'h18;
    #1 check("nc_store_notready_dropped", rdata_nc, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
